wb_port_arbiter: RTL

Shares the single register-file write port between the in-order pipeline writeback path (the `WB_data`/`WB_rd` pair produced by the writeback stage) and a long-latency unit (LLU, e.g. multi-cycle mul/div).

- LLU results are queued in a small FIFO.
- The pipeline has priority; a starvation counter forces an LLU drain by stalling the pipeline.
- The write port output is registered, so the register file sees one write per cycle at most.

---
 rtl/wb_port_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module   : wb_port_arbiter
// Brief    : Shares the register-file write port between pipeline writeback
//            and a FIFO of long-latency unit results, with starvation forcing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  output logic        pipe_stall,
  input  logic        llu_vld,
  input  logic [4:0]  llu_rd,
  input  logic [31:0] llu_data,
  output logic        llu_rdy,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata
);

  localparam int          c_PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          c_CNT_W      = $clog2(DEPTH + 1);
  localparam int          c_STV_W      = $clog2(STARVE_MAX + 1);
  localparam logic [4:0]  c_ZERO_REG   = 5'd0;
  localparam logic [c_CNT_W-1:0] c_DEPTH      = c_CNT_W'(DEPTH);
  localparam logic [c_STV_W-1:0] c_STARVE_MAX = c_STV_W'(STARVE_MAX);

  typedef enum logic [0:0] {
    PIPE_PRIO = 1'b0,
    LLU_FORCE = 1'b1
  } arb_state_t;

  logic [4:0]         r_mem_rd   [DEPTH];
  logic [31:0]        r_mem_data [DEPTH];
  logic [c_PTR_W-1:0] r_head, r_tail;
  logic [c_CNT_W-1:0] r_count, w_count_nxt;
  logic [c_STV_W-1:0] r_starve, w_starve_nxt;
  arb_state_t         w_state;

  logic        w_pipe_req, w_buf_ne, w_push, w_pop;
  logic        w_grant_llu, w_grant_pipe;
  logic [4:0]  w_wr_rd;
  logic [31:0] w_wr_data;

  assign w_pipe_req = (pipe_rd != c_ZERO_REG);
  assign w_buf_ne   = (r_count != '0);
  assign llu_rdy    = (r_count < c_DEPTH);
  assign w_push     = llu_vld && llu_rdy && (llu_rd != c_ZERO_REG);
  // The forced state is a pure decode of registered starve/count, not a stored bit.
  assign w_state    = ((r_starve == c_STARVE_MAX) && w_buf_ne) ? LLU_FORCE : PIPE_PRIO;

  always_comb begin
    w_grant_llu  = 1'b0;
    w_grant_pipe = 1'b0;
    w_pop        = 1'b0;
    pipe_stall   = 1'b0;
    w_starve_nxt = '0;
    w_wr_rd      = pipe_rd;
    w_wr_data    = pipe_data;
    if (w_buf_ne && (!w_pipe_req || (w_state == LLU_FORCE))) begin
      w_grant_llu = 1'b1;
      w_pop       = 1'b1;
      pipe_stall  = w_pipe_req;
      w_wr_rd     = r_mem_rd[r_head];
      w_wr_data   = r_mem_data[r_head];
    end else if (w_pipe_req) begin
      w_grant_pipe = 1'b1;
      if (w_buf_ne) begin
        w_starve_nxt = (r_starve == c_STARVE_MAX) ? r_starve : r_starve + c_STV_W'(1);
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_CNT_W'(1);
      2'b01:   w_count_nxt = r_count - c_CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
      rf_we    <= w_grant_llu || w_grant_pipe;
      if (w_push) r_tail <= r_tail + c_PTR_W'(1);
      if (w_pop)  r_head <= r_head + c_PTR_W'(1);
      if (w_grant_llu || w_grant_pipe) begin
        rf_rd    <= w_wr_rd;
        rf_wdata <= w_wr_data;
      end
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_tail]   <= llu_rd;
      r_mem_data[r_tail] <= llu_data;
    end
  end

endmodule

`default_nettype wire
